// File: rtl/vector_lane_sequencer_if.sv
// rtl/vector_lane_sequencer_if.sv - instruction issue and lane-datapath control bundle for the vector lane sequencer
//
// Purpose: groups the decoded-instruction handshake and the register-file /
// ALU / writeback control outputs of the sequencer into one bundle.
// Ports (all signals, grouped by modport direction as seen from the sequencer):
//   instruction in : start_i, op_i[3:0], use_imm_i, vd_i/vs1_i/vs2_i[2:0], imm_i[9:0], stall_i
//   status out     : ready_o, done_o, error_o
//   read side out  : rf_rd_en_o, rf_rs1_o, rf_rs2_o, lane_idx_o, src_b_imm_o, imm_o, alu_op_o
//   write side out : wr_en_o, wr_addr_o, wr_lane_o
// master = instruction issuer / datapath, slave = the sequencer.

interface vector_lane_sequencer_if #(
    parameter int LANES = 8
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic          start_i;
    logic          ready_o;
    logic [3:0]    op_i;
    logic          use_imm_i;
    logic [2:0]    vd_i;
    logic [2:0]    vs1_i;
    logic [2:0]    vs2_i;
    logic [9:0]    imm_i;
    logic          stall_i;
    logic          rf_rd_en_o;
    logic [2:0]    rf_rs1_o;
    logic [2:0]    rf_rs2_o;
    logic [LW-1:0] lane_idx_o;
    logic          src_b_imm_o;
    logic [7:0]    imm_o;
    logic [3:0]    alu_op_o;
    logic          wr_en_o;
    logic [2:0]    wr_addr_o;
    logic [LW-1:0] wr_lane_o;
    logic          done_o;
    logic          error_o;

    modport master (
        output start_i, op_i, use_imm_i, vd_i, vs1_i, vs2_i, imm_i, stall_i,
        input  ready_o, rf_rd_en_o, rf_rs1_o, rf_rs2_o, lane_idx_o, src_b_imm_o,
               imm_o, alu_op_o, wr_en_o, wr_addr_o, wr_lane_o, done_o, error_o
    );

    modport slave (
        input  start_i, op_i, use_imm_i, vd_i, vs1_i, vs2_i, imm_i, stall_i,
        output ready_o, rf_rd_en_o, rf_rs1_o, rf_rs2_o, lane_idx_o, src_b_imm_o,
               imm_o, alu_op_o, wr_en_o, wr_addr_o, wr_lane_o, done_o, error_o
    );
endinterface

// File: rtl/vector_lane_sequencer.sv
// rtl/vector_lane_sequencer.sv - issue-side beat sequencer for vector ALU instructions
//
// Purpose: accepts one decoded vector instruction, then walks the shared lane
// datapath through LANES lanes in beats of PER_BEAT lanes, with a one-cycle
// read-to-writeback pipeline, stall support and a completion pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : vector_lane_sequencer_if.slave (instruction in, RF/ALU/writeback control out)
// Parameters: N (lane data width, not used by the control logic), LANES, PER_BEAT.

module vector_lane_sequencer #(
    parameter int N        = 32,
    parameter int LANES    = 8,
    parameter int PER_BEAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vector_lane_sequencer_if.slave bus
);
    localparam int B   = LANES / PER_BEAT;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW  = (B > 1) ? $clog2(B) : 1;
    localparam int PSH = $clog2(PER_BEAT);
    localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

    // Data width only matters to the lane datapath fed by this block.
    localparam int unused_data_width = N;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q;
    logic          pipe_valid_q;
    logic [LW-1:0] pipe_lane_q;
    logic [3:0]    op_q;
    logic          use_imm_q;
    logic [2:0]    vd_q, vs1_q, vs2_q;
    logic [7:0]    imm_q;
    logic          error_q;

    logic          ready_c, rd_en_c, wr_en_c, done_c;
    logic          accept, reject, advance, pipe_clear;
    logic [LW-1:0] lane_idx;
    logic          unused_imm_hi;

    assign unused_imm_hi = ^bus.imm_i[9:8];
    assign lane_idx      = LW'(beat_q) << PSH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_c    = 1'b0;
        rd_en_c    = 1'b0;
        wr_en_c    = pipe_valid_q;
        done_c     = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        advance    = 1'b0;
        pipe_clear = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c    = 1'b1;
                pipe_clear = 1'b1;
                if (bus.start_i) begin
                    if (bus.op_i < 4'hC) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.stall_i) begin
                    wr_en_c = 1'b0;
                end else begin
                    rd_en_c = 1'b1;
                    advance = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.stall_i) begin
                    wr_en_c = 1'b0;
                end else begin
                    // Final beat is written this cycle; nothing is left in flight.
                    pipe_clear = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                pipe_clear = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q       <= '0;
            pipe_valid_q <= 1'b0;
            pipe_lane_q  <= '0;
            op_q         <= '0;
            use_imm_q    <= 1'b0;
            vd_q         <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            imm_q        <= '0;
            error_q      <= 1'b0;
        end else begin
            error_q <= reject;
            if (accept) begin
                op_q      <= bus.op_i;
                use_imm_q <= bus.use_imm_i;
                vd_q      <= bus.vd_i;
                vs1_q     <= bus.vs1_i;
                vs2_q     <= bus.vs2_i;
                imm_q     <= bus.imm_i[7:0];
                beat_q    <= '0;
            end
            if (advance) begin
                // Beat counter wraps to zero after the last beat since B is a power of two.
                beat_q       <= beat_q + 1'b1;
                pipe_valid_q <= 1'b1;
                pipe_lane_q  <= lane_idx;
            end else if (pipe_clear) begin
                pipe_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ready_o     = ready_c;
    assign bus.rf_rd_en_o  = rd_en_c;
    assign bus.rf_rs1_o    = vs1_q;
    assign bus.rf_rs2_o    = vs2_q;
    assign bus.lane_idx_o  = lane_idx;
    assign bus.src_b_imm_o = use_imm_q;
    assign bus.imm_o       = imm_q;
    assign bus.alu_op_o    = op_q;
    assign bus.wr_en_o     = wr_en_c;
    assign bus.wr_addr_o   = vd_q;
    assign bus.wr_lane_o   = pipe_lane_q;
    assign bus.done_o      = done_c;
    assign bus.error_o     = error_q;
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb/tb_vector_lane_sequencer.sv - directed self-checking bench for vector_lane_sequencer

module tb_vector_lane_sequencer;
    localparam int NCYC = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    vector_lane_sequencer_if #(.LANES(8)) bus ();

    vector_lane_sequencer #(.N(32), .LANES(8), .PER_BEAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Per-run observations, cycle c = the cycle after start-capture edge c-1.
    logic [11:0] rd_m, wr_m, done_m, rdy_m, err_m;
    logic [31:0] rd_seq, wr_seq;
    int          wr_cnt;
    logic [3:0]  f_op    [12];
    logic [7:0]  f_imm   [12];
    logic        f_src   [12];
    logic [2:0]  f_waddr [12];
    logic [2:0]  f_rs1   [12];
    logic [2:0]  f_rs2   [12];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int c);
        rd_m[c]   = bus.rf_rd_en_o;
        wr_m[c]   = bus.wr_en_o;
        done_m[c] = bus.done_o;
        rdy_m[c]  = bus.ready_o;
        err_m[c]  = bus.error_o;
        if (bus.rf_rd_en_o) rd_seq = {rd_seq[28:0], bus.lane_idx_o};
        if (bus.wr_en_o) begin
            wr_seq = {wr_seq[28:0], bus.wr_lane_o};
            wr_cnt++;
        end
        f_op[c]    = bus.alu_op_o;
        f_imm[c]   = bus.imm_o;
        f_src[c]   = bus.src_b_imm_o;
        f_waddr[c] = bus.wr_addr_o;
        f_rs1[c]   = bus.rf_rs1_o;
        f_rs2[c]   = bus.rf_rs2_o;
    endtask

    // Called at a negedge: start is high in cycle 0, stall_mask bit c applies
    // in cycle c, and a second start with different fields is pulsed in inj_cycle.
    task automatic run_seq(input logic [3:0] op, input logic [2:0] vd, input logic [2:0] vs1,
                           input logic [2:0] vs2, input logic ui, input logic [9:0] imm,
                           input logic [15:0] stall_mask, input int inj_cycle);
        rd_m = '0; wr_m = '0; done_m = '0; rdy_m = '0; err_m = '0;
        rd_seq = '0; wr_seq = '0; wr_cnt = 0;
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.vd_i      = vd;
        bus.vs1_i     = vs1;
        bus.vs2_i     = vs2;
        bus.use_imm_i = ui;
        bus.imm_i     = imm;
        bus.stall_i   = stall_mask[0];
        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = (c == inj_cycle);
            if (c == inj_cycle) begin
                bus.op_i      = 4'h5;
                bus.vd_i      = 3'd7;
                bus.vs1_i     = 3'd6;
                bus.vs2_i     = 3'd5;
                bus.use_imm_i = ~ui;
                bus.imm_i     = 10'h0FF;
            end
            bus.stall_i = stall_mask[c];
            @(negedge clk);
            sample(c);
        end
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.op_i      = '0;
        bus.vd_i      = '0;
        bus.vs1_i     = '0;
        bus.vs2_i     = '0;
        bus.use_imm_i = 1'b0;
        bus.imm_i     = '0;
        bus.stall_i   = 1'b0;

        #2;
        check("rst_ready",   32'(bus.ready_o), 32'd1);
        check("rst_rd_en",   32'(bus.rf_rd_en_o), 32'd0);
        check("rst_wr_en",   32'(bus.wr_en_o), 32'd0);
        check("rst_done",    32'(bus.done_o), 32'd0);
        check("rst_error",   32'(bus.error_o), 32'd0);
        check("rst_alu_op",  32'(bus.alu_op_o), 32'd0);
        check("rst_lane",    32'(bus.lane_idx_o), 32'd0);
        check("rst_imm",     32'(bus.imm_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain op, no stall.
        run_seq(4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 10'h000, 16'h0000, -1);
        check("t1_rd_mask",   32'(rd_m),   32'h01E);
        check("t1_wr_mask",   32'(wr_m),   32'h03C);
        check("t1_done_mask", 32'(done_m), 32'h040);
        check("t1_rdy_mask",  32'(rdy_m),  32'hF80);
        check("t1_err_mask",  32'(err_m),  32'h000);
        check("t1_rd_lanes",  rd_seq,      32'h0A6);
        check("t1_wr_lanes",  wr_seq,      32'h0A6);
        check("t1_wr_cnt",    32'(wr_cnt), 32'd4);
        check("t1_wr_addr",   32'(f_waddr[2]), 32'd1);
        check("t1_rs1",       32'(f_rs1[1]), 32'd2);
        check("t1_rs2",       32'(f_rs2[1]), 32'd3);
        check("t1_alu_op",    32'(f_op[1]),  32'd3);
        check("t1_src_b",     32'(f_src[1]), 32'd0);

        // Immediate operand: only imm[7:0] latched, held through the op.
        run_seq(4'h0, 3'd4, 3'd5, 3'd6, 1'b1, 10'h3A5, 16'h0000, -1);
        check("t2_imm_c1",  32'(f_imm[1]), 32'hA5);
        check("t2_imm_c6",  32'(f_imm[6]), 32'hA5);
        check("t2_src_c1",  32'(f_src[1]), 32'd1);
        check("t2_src_c5",  32'(f_src[5]), 32'd1);
        check("t2_rd_mask", 32'(rd_m),     32'h01E);

        // Stall in cycles 2-3.
        run_seq(4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 10'h000, 16'h000C, -1);
        check("t3_rd_mask",   32'(rd_m),   32'h072);
        check("t3_wr_mask",   32'(wr_m),   32'h0F0);
        check("t3_done_mask", 32'(done_m), 32'h100);
        check("t3_rdy_mask",  32'(rdy_m),  32'hE00);
        check("t3_rd_lanes",  rd_seq,      32'h0A6);
        check("t3_wr_lanes",  wr_seq,      32'h0A6);
        check("t3_wr_cnt",    32'(wr_cnt), 32'd4);

        // Reserved opcode: rejected, nothing latched.
        run_seq(4'hD, 3'd7, 3'd7, 3'd7, 1'b1, 10'h055, 16'h0000, -1);
        check("t4_err_mask",  32'(err_m),  32'h002);
        check("t4_rdy_mask",  32'(rdy_m),  32'hFFE);
        check("t4_rd_mask",   32'(rd_m),   32'h000);
        check("t4_wr_mask",   32'(wr_m),   32'h000);
        check("t4_done_mask", 32'(done_m), 32'h000);
        check("t4_op_held",   32'(f_op[2]), 32'd3);
        check("t4_imm_held",  32'(f_imm[2]), 32'd0);

        // Start pulsed mid-RUN with other fields is ignored.
        run_seq(4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 10'h000, 16'h0000, 3);
        check("t5_rd_mask",  32'(rd_m),       32'h01E);
        check("t5_wr_mask",  32'(wr_m),       32'h03C);
        check("t5_wr_lanes", wr_seq,          32'h0A6);
        check("t5_alu_op",   32'(f_op[4]),    32'd3);
        check("t5_rs1",      32'(f_rs1[4]),   32'd2);
        check("t5_rs2",      32'(f_rs2[4]),   32'd3);
        check("t5_src_b",    32'(f_src[4]),   32'd0);
        check("t5_wr_addr",  32'(f_waddr[5]), 32'd1);
        check("t5_err_mask", 32'(err_m),      32'h000);

        // Reset in cycle 3 of a running op.
        bus.start_i   = 1'b1;
        bus.op_i      = 4'h7;
        bus.vd_i      = 3'd2;
        bus.vs1_i     = 3'd4;
        bus.vs2_i     = 3'd6;
        bus.use_imm_i = 1'b1;
        bus.imm_i     = 10'h1C3;
        bus.stall_i   = 1'b0;
        @(posedge clk); #1; bus.start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_pre_rd_en", 32'(bus.rf_rd_en_o), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_ready",  32'(bus.ready_o), 32'd1);
        check("t6_rst_rd_en",  32'(bus.rf_rd_en_o), 32'd0);
        check("t6_rst_wr_en",  32'(bus.wr_en_o), 32'd0);
        check("t6_rst_alu_op", 32'(bus.alu_op_o), 32'd0);
        check("t6_rst_waddr",  32'(bus.wr_addr_o), 32'd0);
        check("t6_rst_imm",    32'(bus.imm_o), 32'd0);
        check("t6_rst_src_b",  32'(bus.src_b_imm_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_seq(4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 10'h000, 16'h0000, -1);
        check("t6_rd_mask",   32'(rd_m),   32'h01E);
        check("t6_wr_mask",   32'(wr_m),   32'h03C);
        check("t6_done_mask", 32'(done_m), 32'h040);
        check("t6_wr_lanes",  wr_seq,      32'h0A6);
        check("t6_wr_cnt",    32'(wr_cnt), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Issue-side controller for vector ALU instructions in the vector CPU.
- Accepts one decoded vector instruction and steps the shared lane datapath through the vector in beats of PER_BEAT lanes.
- Drives register-file read and write enables and addresses, the lane index, the ALU opcode, and the operand-B select between vector register vs2 and the broadcast 8-bit immediate from the extend unit.
- Runs a 1-cycle read-to-writeback pipeline, supports a stall input, and signals completion.

Parameters:
- N, 32, lane data width (passed through only; no width-dependent logic here).
- LANES, 8, vector length in lanes; power of two.
- PER_BEAT, 2, lanes processed per beat; power of two, divides LANES. B = LANES/PER_BEAT beats.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  instruction valid.
- ready_o  out  1  block idle and can accept start_i.
- op_i  in  4  ALU opcode; 4'hC..4'hF are reserved.
- use_imm_i  in  1  operand B taken from the immediate instead of vs2.
- vd_i, vs1_i, vs2_i  in  3 each  vector register indices.
- imm_i  in  10  raw immediate field; only [7:0] is used.
- stall_i  in  1  downstream stall.
- rf_rd_en_o  out  1  register-file read strobe.
- rf_rs1_o, rf_rs2_o  out  3 each  latched vs1 and vs2.
- lane_idx_o  out  clog2(LANES)  first lane of the current read beat.
- src_b_imm_o  out  1  latched use_imm_i.
- imm_o  out  8  latched imm_i[7:0], fed to the extend unit.
- alu_op_o  out  4  latched op_i.
- wr_en_o  out  1  writeback strobe.
- wr_addr_o  out  3  latched vd.
- wr_lane_o  out  clog2(LANES)  first lane of the beat being written.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  one-cycle pulse on a rejected instruction.

Behaviour:
- Reset values:
  - State is IDLE, so ready_o=1.
  - All other outputs are 0, including the latched fields, beat counter and write pipeline register.
  - Asserting rst at any point, including mid-vector, aborts immediately with no further writes.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 with op_i<4'hC: latch op, use_imm, vd, vs1, vs2 and imm[7:0]; clear beat; go to RUN next cycle.
  - start_i=1 with op_i>=4'hC: no latch, error_o=1 for the next cycle, stay in IDLE.
- ready_o=0 in RUN, DRAIN and DONE. start_i is ignored there and the latched fields are held.
- RUN:
  - rf_rd_en_o=1 and lane_idx_o=beat*PER_BEAT.
  - Each unstalled cycle: write pipeline register <= {valid=1, lane=lane_idx}; beat increments.
  - When beat=B-1 and unstalled, go to DRAIN.
- Writeback:
  - wr_en_o equals the pipeline valid bit and wr_lane_o equals the pipeline lane.
  - The pipeline valid bit is cleared in IDLE and DONE.
- DRAIN: writes the final beat, then goes to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Timing with no stall (start accepted at edge 0):
  - RUN occupies cycles 1..B.
  - Writes occur in cycles 2..B+1, exactly B writes.
  - done_o is high in cycle B+2.
  - ready_o returns in cycle B+3.
- stall_i=1 in RUN or DRAIN:
  - Freezes state, beat and the write pipeline.
  - rf_rd_en_o and wr_en_o are forced to 0 that cycle.
  - No beat is lost or duplicated.
- stall_i has no effect in IDLE or DONE.
- Back-to-back instructions: the next start is accepted in the first IDLE cycle.
- Lanes are written in ascending order.
- vd may equal vs1 or vs2, with no hazard, because every lane is read before its own write.

Test Plan:
- LANES=8, PER_BEAT=2, no stall; start with op=3, vd=1, vs1=2, vs2=3, use_imm=0 -> rf_rd_en in cycles 1-4 with lane_idx 0,2,4,6; wr_en in cycles 2-5 with wr_lane 0,2,4,6 and wr_addr=1; done_o in cycle 6; ready_o in cycle 7.
- use_imm=1, imm_i=10'h3A5 -> imm_o=8'hA5 and src_b_imm_o=1 held through the whole op.
- stall_i high in cycles 2-3 -> read lane 2 is issued in cycle 4; the write sequence is still 0,2,4,6 with no duplicates; done_o moves to cycle 8.
- op_i=4'hD with start -> error_o pulses in cycle 1; ready_o stays 1; no rd_en or wr_en.
- start_i pulsed in cycle 3 during RUN with different fields -> ignored; latched outputs unchanged.
- rst asserted in cycle 3 -> outputs drop to 0 asynchronously and ready_o=1; after release the next start runs a clean full sequence.
